// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with a TX FIFO, a one-entry RX holding register and a level irq.
// Define UART_RX_EN to build the receive path; without it rxd is ignored and RX status reads as empty.
module uart_mmio #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd868
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [11:0]     addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid,
  output logic            txd,
  input  logic            rxd,
  output logic            irq
);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [9:0] off;
  logic       wr, rd;
  assign off = addr[11:2];
  assign wr  = req & we;
  assign rd  = req & ~we;

  logic [DW-1:0] div_q;
  logic          txe_ie_q;
  logic          rx_valid, rx_overrun, rxv_ie;
  logic [7:0]    rx_byte;
  logic          unused_bits;

  // Control registers; DIV is clamped so half-bit RX timing stays non-zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DIV_RESET;
      txe_ie_q <= 1'b0;
    end else if (wr) begin
      if (off == 10'd3) div_q <= (wdata[DW-1:0] < DW'(2)) ? DW'(2) : wdata[DW-1:0];
      if (off == 10'd4) txe_ie_q <= wdata[0];
    end
  end

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_empty, tx_full, tx_push, tx_pop, tx_empty;

  assign fifo_empty = (count_q == '0);
  assign tx_full    = (count_q == CW'(TX_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign tx_push    = wr && (off == 10'd0) && (!tx_full || tx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (tx_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  state_t        tx_state_q, tx_state_d;
  logic [DW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd        <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd        <= txd_d;
    end
  end

  // TX sequencer; the bit counter reloads from DIV at every bit boundary
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q - DW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = fifo_mem[rd_ptr_q];
          tx_cnt_d   = div_q - DW'(1);
          txd_d      = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_bit_d   = '0;
          tx_cnt_d   = div_q - DW'(1);
          txd_d      = tx_shift_q[0];
        end
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = div_q - DW'(1);
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          if (!fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = fifo_mem[rd_ptr_q];
            tx_cnt_d   = div_q - DW'(1);
            txd_d      = 1'b0;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
            txd_d      = 1'b1;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  assign tx_empty = fifo_empty && (tx_state_q == S_IDLE);

`ifdef UART_RX_EN
  logic [1:0]    rx_sync_q;
  logic          rx_s, rx_prev_q, rx_load;
  state_t        rx_state_q, rx_state_d;
  logic [DW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_valid_q, rx_overrun_q, rxv_ie_q;
  logic [7:0]    rx_byte_q;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rxd};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX sequencer: half-bit wait rejects start glitches, then one sample per bit period
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q - DW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s) begin
          rx_state_d = S_START;
          rx_cnt_d   = {1'b0, div_q[DW-1:1]} - DW'(1);
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = div_q - DW'(1);
          rx_bit_d   = '0;
          rx_state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = div_q - DW'(1);
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_load    = rx_s;
          rx_state_d = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Holding register: a new byte beats a concurrent RXDATA read and is not an overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rxv_ie_q     <= 1'b0;
    end else begin
      if (rx_load) begin
        rx_byte_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
      end else if (rd && off == 10'd1) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_load && rx_valid_q && !(rd && off == 10'd1)) rx_overrun_q <= 1'b1;
      else if (rd && off == 10'd2)                          rx_overrun_q <= 1'b0;
      if (wr && off == 10'd4) rxv_ie_q <= wdata[1];
    end
  end

  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;
  assign rx_byte     = rx_byte_q;
  assign rxv_ie      = rxv_ie_q;
  assign unused_bits = ^{wdata[XLEN-1:DW], addr[1:0]};
`else
  assign rx_valid    = 1'b0;
  assign rx_overrun  = 1'b0;
  assign rx_byte     = '0;
  assign rxv_ie      = 1'b0;
  assign unused_bits = ^{wdata[XLEN-1:DW], addr[1:0], rxd};
`endif

  logic [XLEN-1:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    case (off)
      10'd0: rdata_c[XLEN-1] = tx_full;
      10'd1: begin
        rdata_c[XLEN-1] = ~rx_valid;
        rdata_c[7:0]    = rx_valid ? rx_byte : 8'h00;
      end
      10'd2: rdata_c[3:0]  = {rx_overrun, rx_valid, tx_full, tx_empty};
      10'd3: rdata_c[15:0] = div_q;
      10'd4: rdata_c[1:0]  = {rxv_ie, txe_ie_q};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      irq    <= 1'b0;
    end else begin
      rdata  <= rd ? rdata_c : '0;
      rvalid <= rd;
      irq    <= (txe_ie_q & tx_empty) | (rxv_ie & rx_valid);
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register reads and decoded TX frames go through scoreboard queues.
module tb_uart_mmio;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        txd;
  logic        rxd = 1'b1;
  logic        irq;

  localparam int CLK_PERIOD = 10;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_div  = 868;

  logic [31:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  mon_q[$];
  time         mon_t_q[$];

  uart_mmio dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .txd(txd), .rxd(rxd), .irq(irq)
  );

  always #(CLK_PERIOD/2) clk = ~clk;

  // Serial monitor: decodes txd frames mid-bit at the current divisor
  initial begin
    logic [7:0] mb;
    time        mt;
    int         md;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        mt = $time;
        md = cur_div;
        repeat (md/2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (md) @(negedge clk);
          mb[k] = txd;
        end
        repeat (md) @(negedge clk);
        mon_q.push_back(mb);
        mon_t_q.push_back(mt);
      end
    end
  end

  initial begin
    #(CLK_PERIOD * 40000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk); req = 1'b0; we = 1'b0; wdata = '0;
    if (a == 12'h00C) cur_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
  endtask

  // Read data must be valid exactly one cycle after the request
  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk); req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk); req = 1'b0;
    d = (rvalid === 1'b1) ? rdata : 32'hxxxx_xxxx;
  endtask

  task automatic send_rx(input logic [7:0] b, input int d, input logic stop);
    rxd = 1'b0; repeat (d) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k]; repeat (d) @(negedge clk);
    end
    rxd = stop; repeat (d) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] got, e;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (txd !== 1'b1)   begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_checks++; if (irq !== 1'b0)   begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    rd_exp_q.push_back(32'h1);
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL reset_status: got %h expected %h", got, e); end
    rd_exp_q.push_back(32'd868);
    bus_read(12'h00C, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL reset_div: got %h expected %h", got, e); end
    rd_exp_q.push_back(32'h0);
    bus_read(12'h010, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL reset_ie: got %h expected %h", got, e); end
    n_checks++; if (txd !== 1'b1 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_pins: got txd=%b irq=%b expected txd=1 irq=0", txd, irq);
    end
  endtask

  task automatic test_div;
    logic [31:0] got, e;
    bus_write(12'h00C, 32'h1);
    rd_exp_q.push_back(32'h2);
    bus_read(12'h00C, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL div_clamp: got %h expected %h", got, e); end
    bus_write(12'h020, 32'h55);
    rd_exp_q.push_back(32'h0);
    bus_read(12'h020, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL unmapped_read: got %h expected %h", got, e); end
    rd_exp_q.push_back(32'h2);
    bus_read(12'h00C, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL unmapped_write_ignored: got %h expected %h", got, e); end
    bus_write(12'h00C, 32'hFFFF_0004);
    rd_exp_q.push_back(32'h4);
    bus_read(12'h00C, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL div_write: got %h expected %h", got, e); end
  endtask

  task automatic test_tx_frame;
    logic [31:0] got, e;
    logic [9:0]  bits;
    logic [7:0]  b, m;
    b = 8'hA5;
    bits = {1'b1, b, 1'b0};
    mon_q.delete(); mon_t_q.delete();
    tx_exp_q.push_back(b);
    bus_write(12'h000, {24'h0, b});
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL tx_start_latency: got %b expected 1", txd); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== bits[i/4]) begin
        n_fail++; $display("FAIL tx_bit_cycle%0d: got %b expected %b", i, txd, bits[i/4]);
      end
    end
    @(negedge clk);
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after_frame: got %b expected 1", txd); end
    rd_exp_q.push_back(32'h1);
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL tx_empty_after_frame: got %h expected %h", got, e); end
    n_checks++;
    if (mon_q.size() != 1) begin
      n_fail++; $display("FAIL tx_frame_count: got %0d expected 1", mon_q.size());
    end else begin
      m = mon_q.pop_front(); b = tx_exp_q.pop_front();
      n_checks++; if (m !== b) begin n_fail++; $display("FAIL tx_frame_byte: got %h expected %h", m, b); end
    end
    tx_exp_q.delete(); mon_t_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [31:0] got, e;
    logic [7:0]  b, m;
    time         t_prev, t_cur;
    bus_write(12'h00C, 32'h2);
    mon_q.delete(); mon_t_q.delete(); tx_exp_q.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      @(negedge clk); req = 1'b1; we = 1'b1; addr = 12'h000; wdata = {24'h0, b};
      tx_exp_q.push_back(b);
    end
    @(negedge clk); req = 1'b0; we = 1'b0;
    rd_exp_q.push_back(32'h8000_0000);
    bus_read(12'h000, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL b2b_full_after_9: got %h expected %h", got, e); end
    bus_write(12'h000, 32'hEE);
    rd_exp_q.push_back(32'h8000_0000);
    bus_read(12'h000, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL b2b_full_after_10: got %h expected %h", got, e); end
    rd_exp_q.push_back(32'h2);
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL b2b_status_busy: got %h expected %h", got, e); end
    for (int i = 0; i < 400 && mon_q.size() < 9; i++) @(negedge clk);
    repeat (60) @(negedge clk);
    n_checks++;
    if (mon_q.size() != 9) begin
      n_fail++; $display("FAIL b2b_frame_count: got %0d expected 9", mon_q.size());
    end
    t_prev = 0;
    for (int i = 0; i < 9 && mon_q.size() > 0; i++) begin
      m = mon_q.pop_front(); b = tx_exp_q.pop_front(); t_cur = mon_t_q.pop_front();
      n_checks++; if (m !== b) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, m, b); end
      if (i > 0) begin
        n_checks++;
        if (t_cur - t_prev != time'(20 * CLK_PERIOD)) begin
          n_fail++; $display("FAIL b2b_gap%0d: got %0t expected %0d", i, t_cur - t_prev, 20 * CLK_PERIOD);
        end
      end
      t_prev = t_cur;
    end
    tx_exp_q.delete(); mon_t_q.delete(); mon_q.delete();
  endtask

`ifdef UART_RX_EN
  task automatic test_rx;
    logic [31:0] got, e;
    bus_write(12'h00C, 32'h8);
    send_rx(8'h3C, 8, 1'b1);
    repeat (4) @(negedge clk);
    rd_exp_q.push_back(32'h5);
    rd_exp_q.push_back(32'h3C);
    rd_exp_q.push_back(32'h8000_0000);
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rx_status_valid: got %h expected %h", got, e); end
    bus_read(12'h004, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rx_data: got %h expected %h", got, e); end
    bus_read(12'h004, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rx_data_empty: got %h expected %h", got, e); end
    send_rx(8'h55, 8, 1'b0);
    repeat (4) @(negedge clk);
    rd_exp_q.push_back(32'h1);
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rx_bad_stop_dropped: got %h expected %h", got, e); end
    rxd = 1'b0; repeat (2) @(negedge clk); rxd = 1'b1;
    repeat (20) @(negedge clk);
    rd_exp_q.push_back(32'h1);
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rx_glitch_rejected: got %h expected %h", got, e); end
  endtask

  task automatic test_overrun;
    logic [31:0] got, e;
    send_rx(8'h11, 8, 1'b1);
    send_rx(8'h22, 8, 1'b1);
    repeat (4) @(negedge clk);
    rd_exp_q.push_back(32'h22);
    rd_exp_q.push_back(32'h9);
    rd_exp_q.push_back(32'h1);
    bus_read(12'h004, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL overrun_data: got %h expected %h", got, e); end
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL overrun_flag: got %h expected %h", got, e); end
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL overrun_cleared: got %h expected %h", got, e); end
  endtask
`else
  task automatic test_rx_disabled;
    logic [31:0] got, e;
    bus_write(12'h00C, 32'h8);
    send_rx(8'h3C, 8, 1'b1);
    repeat (4) @(negedge clk);
    rd_exp_q.push_back(32'h1);
    rd_exp_q.push_back(32'h8000_0000);
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rxoff_status: got %h expected %h", got, e); end
    bus_read(12'h004, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL rxoff_rxdata: got %h expected %h", got, e); end
  endtask
`endif

  task automatic test_irq;
    logic [31:0] got, e;
    bus_write(12'h010, 32'h3);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag_rise: got %b expected 0", irq); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_txe: got %b expected 1", irq); end
`ifdef UART_RX_EN
    rd_exp_q.push_back(32'h3);
`else
    rd_exp_q.push_back(32'h1);
`endif
    bus_read(12'h010, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL ie_readback: got %h expected %h", got, e); end
    bus_write(12'h010, 32'h2);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_lag_fall: got %b expected 1", irq); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b expected 0", irq); end
    send_rx(8'h7E, 8, 1'b1);
    repeat (4) @(negedge clk);
`ifdef UART_RX_EN
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rxv: got %b expected 1", irq); end
    rd_exp_q.push_back(32'h7E);
    bus_read(12'h004, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL irq_rx_data: got %h expected %h", got, e); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rxv_cleared: got %b expected 0", irq); end
`else
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_rx_disabled: got %b expected 0", irq); end
`endif
    bus_write(12'h010, 32'h0);
  endtask

  task automatic test_reset_midframe;
    logic [31:0] got, e;
    bus_write(12'h00C, 32'h4);
    bus_write(12'h000, 32'h00);
    repeat (8) @(negedge clk);
    n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL midframe_low: got %b expected 0", txd); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_txd: got %b expected 1", txd); end
    @(negedge clk); rst_n = 1'b1; cur_div = 868;
    @(negedge clk);
    rd_exp_q.push_back(32'h1);
    rd_exp_q.push_back(32'd868);
    bus_read(12'h008, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL midframe_status: got %h expected %h", got, e); end
    bus_read(12'h00C, got); e = rd_exp_q.pop_front();
    n_checks++; if (got !== e) begin n_fail++; $display("FAIL midframe_div: got %h expected %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_div();
    test_tx_frame();
    test_back_to_back();
`ifdef UART_RX_EN
    test_rx();
    test_overrun();
`else
    test_rx_disabled();
`endif
    test_irq();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
